// File: rtl/datapath_control.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_control
//  Description : Moore-FSM control unit for the bus datapath. Fetches one
//                8-bit instruction per FETCH state by pulsing the PC
//                `increment` strobe. Each following state then sequences one
//                bus transfer with one-hot `rout` (bus driver) and `ren`
//                (register load) words, plus the ALU `addxor` select.
//  Ports       : clock        in   system clock, rising-edge active
//                resetnot     in   asynchronous active-low reset
//                instruction  in   [7:6] opcode, [5:3] rx, [2:0] ry / imm
//                halt         in   park in IDLE at the next boundary
//                rout         out  bus driver select (R0-R7, G, A, EXTERN)
//                ren          out  register load enable (R0-R7, G, A)
//                addxor       out  ALU op, 0 = add, 1 = xor
//                increment    out  registered PC advance strobe
//                done         out  last execute state of an instruction
//                stage        out  debug state code
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_control (
    input  logic        clock,
    input  logic        resetnot,
    input  logic [7:0]  instruction,
    input  logic        halt,
    output logic [15:0] rout,
    output logic [15:0] ren,
    output logic        addxor,
    output logic        increment,
    output logic        done,
    output logic [2:0]  stage
);

    // State codes double as the debug `stage` output.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4
    } state_t;

    localparam logic [1:0]  c_OP_LD   = 2'b01;
    localparam int          c_G_BIT   = 8;
    localparam int          c_A_BIT   = 9;
    localparam logic [15:0] c_EXT_SEL = 16'h0400;

    state_t      r_state_q;
    state_t      w_state_d;
    logic [7:0]  r_ir_q;
    logic [7:0]  w_ir_d;
    logic        r_increment_q;
    logic        w_increment_d;

    logic [1:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic        w_is_alu;
    logic [15:0] w_rx_sel;
    logic [15:0] w_ry_sel;
    state_t      w_boundary_next;

    // Execute states decode only the captured IR, never the live input.
    assign w_op     = r_ir_q[7:6];
    assign w_rx     = r_ir_q[5:3];
    assign w_ry     = r_ir_q[2:0];
    assign w_is_alu = w_op[1];
    assign w_rx_sel = 16'h0001 << w_rx;
    assign w_ry_sel = 16'h0001 << w_ry;

    // halt is only looked at in IDLE and in done states.
    assign w_boundary_next = halt ? S_IDLE : S_FETCH;

    always_comb begin
        w_state_d = r_state_q;
        w_ir_d    = r_ir_q;
        case (r_state_q)
            S_IDLE: begin
                w_state_d = w_boundary_next;
            end
            S_FETCH: begin
                // instruction has settled by the end of FETCH.
                w_ir_d    = instruction;
                w_state_d = S_T1;
            end
            S_T1: begin
                w_state_d = w_is_alu ? S_T2 : w_boundary_next;
            end
            S_T2: begin
                w_state_d = S_T3;
            end
            S_T3: begin
                w_state_d = w_boundary_next;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // The PC uses increment as a clock, so it comes straight from a flop
    // that is set exactly for the cycle spent in FETCH.
    assign w_increment_d = (w_state_d == S_FETCH);

    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            r_state_q     <= S_IDLE;
            r_ir_q        <= 8'h00;
            r_increment_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ir_q        <= w_ir_d;
            r_increment_q <= w_increment_d;
        end
    end

    // Transfer words are decoded from state and IR; the datapath samples
    // them only at the clock edge, so mid-cycle glitches are harmless.
    always_comb begin
        rout   = 16'h0000;
        ren    = 16'h0000;
        addxor = 1'b0;
        done   = 1'b0;
        case (r_state_q)
            S_T1: begin
                if (w_is_alu) begin
                    // A <- Rx
                    rout         = w_rx_sel;
                    ren[c_A_BIT] = 1'b1;
                end else begin
                    // mv: Rx <- Ry, ld: Rx <- EXTERN
                    rout = (w_op == c_OP_LD) ? c_EXT_SEL : w_ry_sel;
                    ren  = w_rx_sel;
                    done = 1'b1;
                end
            end
            S_T2: begin
                // G <- A op Ry; opcode bit 0 selects xor.
                rout         = w_ry_sel;
                ren[c_G_BIT] = 1'b1;
                addxor       = w_op[0];
            end
            S_T3: begin
                // Rx <- G
                rout[c_G_BIT] = 1'b1;
                ren           = w_rx_sel;
                done          = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign increment = r_increment_q;
    assign stage     = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_control
//  Description : Scoreboard bench for datapath_control. Stimulus pushes the
//                expected per-cycle control words; a monitor pops and
//                compares them on every falling edge. A small datapath model
//                runs a short program and the monitor checks R0 results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_control;

    localparam int c_HALF = 5;

    typedef struct packed {
        logic [2:0]  stage;
        logic [15:0] rout;
        logic [15:0] ren;
        logic        addxor;
        logic        increment;
        logic        done;
    } exp_t;

    typedef struct packed {
        logic [15:0] val;
        logic [31:0] cyc;
    } r0_t;

    logic        clock     = 1'b0;
    logic        resetnot  = 1'b0;
    logic        halt      = 1'b0;
    logic [7:0]  instr_drv = 8'hFF;
    logic [7:0]  instruction;
    logic [15:0] rout;
    logic [15:0] ren;
    logic        addxor;
    logic        increment;
    logic        done;
    logic [2:0]  stage;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  exp_q [$];
    string tag_q [$];
    r0_t   r0_q  [$];

    // Datapath model: R0-R7, G (8), A (9), PC and program ROM.
    logic        use_dp = 1'b0;
    logic        dp_clr = 1'b0;
    logic        pc_clr = 1'b0;
    logic [7:0]  pc     = 8'hFF;
    logic [7:0]  rom  [0:255];
    logic [15:0] regs [0:9];
    logic [15:0] bus;

    always #c_HALF clock = ~clock;

    datapath_control u_dut (
        .clock       (clock),
        .resetnot    (resetnot),
        .instruction (instruction),
        .halt        (halt),
        .rout        (rout),
        .ren         (ren),
        .addxor      (addxor),
        .increment   (increment),
        .done        (done),
        .stage       (stage)
    );

    assign instruction = use_dp ? rom[pc] : instr_drv;

    always @(posedge increment or posedge pc_clr) begin
        if (pc_clr) pc <= 8'hFF;
        else        pc <= pc + 8'd1;
    end

    always_comb begin
        bus = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            if (rout[i]) bus = bus | regs[i];
        end
        if (rout[10]) bus = bus | {13'b0, instruction[2:0]};
    end

    always @(posedge clock) begin
        if (dp_clr) begin
            for (int i = 0; i < 10; i++) regs[i] <= 16'h0000;
        end else if (use_dp) begin
            for (int i = 0; i < 10; i++) begin
                if (ren[i]) begin
                    if (i == 8) regs[i] <= addxor ? (regs[9] ^ bus) : (regs[9] + bus);
                    else        regs[i] <= bus;
                end
            end
        end
    end

    function automatic exp_t rec(input logic [2:0] s, input logic [15:0] ro,
                                 input logic [15:0] re, input logic ax,
                                 input logic inc, input logic dn);
        return {s, ro, re, ax, inc, dn};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input exp_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // ---------------- monitor ----------------
    logic        r0_pend    = 1'b0;
    logic        dp_started = 1'b0;
    logic [31:0] dp_cyc     = 0;

    always @(negedge clock) begin
        exp_t  e;
        exp_t  act;
        string t;
        r0_t   r;
        act = {stage, rout, ren, addxor, increment, done};

        check("rout_onehot", {63'b0, ($countones(rout) <= 1) && (rout[15:11] == 5'b0)}, 64'd1);
        check("ren_onehot",  {63'b0, ($countones(ren)  <= 1) && (ren[15:10]  == 6'b0)}, 64'd1);

        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {26'b0, act}, {26'b0, e});
        end

        if (use_dp) begin
            if (!dp_started && stage == 3'd1) begin
                dp_started = 1'b1;
                dp_cyc     = 0;
            end else if (dp_started) begin
                dp_cyc = dp_cyc + 1;
            end
            if (r0_pend) begin
                r0_pend = 1'b0;
                if (r0_q.size() > 0) begin
                    r = r0_q.pop_front();
                    check("r0_value", {48'b0, regs[0]}, {48'b0, r.val});
                    check("r0_cycle", {32'b0, dp_cyc}, {32'b0, r.cyc});
                end
            end
            // The program only adds into R0, so every T3 writes R0.
            if (stage == 3'd4 && done) r0_pend = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d records left, required 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        @(posedge clock); #1;
    endtask

    // Called at posedge+1 with the DUT parked in IDLE (halt=1).
    task automatic start_instr(input logic [7:0] ins, input string nm);
        instr_drv = ins;
        push(rec(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0), {nm, "_idle"});
        push(rec(3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0), {nm, "_fetch"});
        halt = 1'b0;
    endtask

    exp_t c_IDLE;

    initial begin
        c_IDLE = rec(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) rom[i] = 8'h81;      // add R0,R1
        rom[0] = 8'h41;                                    // ld R0,#1
        rom[1] = 8'h4A;                                    // ld R1,#2

        // Reset held with instruction FF, then xor R7,R7 after release.
        @(posedge clock); #1;
        push(c_IDLE, "rst_hold");
        @(posedge clock); #1;
        resetnot = 1'b1;
        push(c_IDLE, "rst_release");
        push(rec(3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0), "rst_fetch");
        push(rec(3'd2, 16'h0080, 16'h0200, 1'b0, 1'b0, 1'b0), "xor77_t1");
        push(rec(3'd3, 16'h0080, 16'h0100, 1'b1, 1'b0, 1'b0), "xor77_t2");
        push(rec(3'd4, 16'h0100, 16'h0080, 1'b0, 1'b0, 1'b1), "xor77_t3");
        push(c_IDLE, "xor77_park");
        @(posedge clock); #1;
        halt = 1'b1;
        drain(20);

        // ld R3,#5 then mv R2,R6 back-to-back; input changes during ld T1.
        start_instr(8'h5D, "ld");
        push(rec(3'd2, 16'h0400, 16'h0008, 1'b0, 1'b0, 1'b1), "ld_t1");
        push(rec(3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0), "ld_mv_fetch");
        push(rec(3'd2, 16'h0040, 16'h0004, 1'b0, 1'b0, 1'b1), "mv_t1");
        push(c_IDLE, "mv_park");
        @(posedge clock); @(posedge clock); #1;
        instr_drv = 8'h16;
        @(posedge clock); #1;
        halt = 1'b1;
        drain(20);

        // add R0,R1 with halt raised during T2; must stay parked.
        start_instr(8'h81, "add");
        push(rec(3'd2, 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0), "add_t1");
        push(rec(3'd3, 16'h0002, 16'h0100, 1'b0, 1'b0, 1'b0), "add_t2");
        push(rec(3'd4, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1), "add_t3");
        for (int i = 0; i < 4; i++) push(c_IDLE, "add_halt_idle");
        @(posedge clock); @(posedge clock); @(posedge clock); #1;
        halt = 1'b1;
        drain(20);

        // xor R0,R1: same words, addxor only in T2.
        start_instr(8'hC1, "xor");
        push(rec(3'd2, 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0), "xor_t1");
        push(rec(3'd3, 16'h0002, 16'h0100, 1'b1, 1'b0, 1'b0), "xor_t2");
        push(rec(3'd4, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1), "xor_t3");
        push(c_IDLE, "xor_park");
        @(posedge clock); #1;
        halt = 1'b1;
        drain(20);

        // add R3,R3 (rx == ry).
        start_instr(8'h9B, "add33");
        push(rec(3'd2, 16'h0008, 16'h0200, 1'b0, 1'b0, 1'b0), "add33_t1");
        push(rec(3'd3, 16'h0008, 16'h0100, 1'b0, 1'b0, 1'b0), "add33_t2");
        push(rec(3'd4, 16'h0100, 16'h0008, 1'b0, 1'b0, 1'b1), "add33_t3");
        push(c_IDLE, "add33_park");
        @(posedge clock); #1;
        halt = 1'b1;
        drain(20);

        // Reset pulsed during T2 of an add, then restart with mv.
        start_instr(8'h81, "rst2");
        push(rec(3'd2, 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0), "rst2_t1");
        push(c_IDLE, "rst2_abort");
        push(c_IDLE, "rst2_released");
        push(rec(3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0), "rst2_refetch");
        push(rec(3'd2, 16'h0040, 16'h0004, 1'b0, 1'b0, 1'b1), "rst2_mv_t1");
        push(c_IDLE, "rst2_park");
        @(posedge clock); @(posedge clock); @(posedge clock); #1;
        resetnot = 1'b0;
        @(posedge clock); #1;
        resetnot = 1'b1;
        @(posedge clock); #1;
        halt      = 1'b1;
        instr_drv = 8'h16;
        drain(20);

        // Integrated program: ld R0,#1; ld R1,#2; add R0,R1 repeated.
        pc_clr = 1'b1;
        dp_clr = 1'b1;
        @(posedge clock); #1;
        pc_clr = 1'b0;
        dp_clr = 1'b0;
        use_dp = 1'b1;
        r0_q.push_back('{val: 16'd3, cyc: 32'd8});
        r0_q.push_back('{val: 16'd5, cyc: 32'd12});
        r0_q.push_back('{val: 16'd7, cyc: 32'd16});
        halt = 1'b0;
        begin
            int n;
            n = 0;
            while (r0_q.size() > 0 && n < 60) begin
                @(negedge clock);
                n++;
            end
            if (r0_q.size() > 0) begin
                n_fail++;
                $display("FAIL r0_timeout: %0d results left, required 0", r0_q.size());
            end
            halt = 1'b1;
            n = 0;
            while (stage != 3'd0 && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("dp_park_stage", {61'b0, stage}, 64'd0);
        end
        @(posedge clock); #1;
        use_dp = 1'b0;
        repeat (2) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
